mips32_pipe: RTL and testbench

- Single-clock, 5-stage (IF/ID/EX/MEM/WB) pipelined MIPS-32-subset core with a unified instruction/data memory and a 32x32 register file.
- Top-level execution block of the MIPS-32 project; benches preload memory and registers hierarchically and run until halt.
- Internal state names are fixed for hierarchical access: PC, HALTED, TAKEN_BRANCH, Memory[0:MEM_DEPTH-1], Register[0:31].

---
 rtl/mips32_pkg.sv | 120 ++++++++++++
 rtl/mips32_alu.sv | 25 ++
 rtl/mips32_pipe.sv | 139 +++++++++++++
 tb/tb_mips32_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline: opcodes, field helpers and pipeline-register layouts.
package mips32_pkg;

    localparam int XLEN_W        = 32;
    localparam int MEM_DEPTH_DEF = 1024;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // OR R0,R0,R0: decodes as an ordinary R-type that never writes
    localparam logic [XLEN_W-1:0] NOP_INSTR = {OP_OR, 26'd0};

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;

    typedef enum logic [2:0] {
        T_NOP, T_RR, T_RI, T_LOAD, T_STORE, T_BRANCH, T_HALT
    } itype_e;

    function automatic logic [5:0] f_op(input logic [XLEN_W-1:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [XLEN_W-1:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [XLEN_W-1:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [XLEN_W-1:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [XLEN_W-1:0] f_imm(input logic [XLEN_W-1:0] ir);
        return {{(XLEN_W-16){ir[15]}}, ir[15:0]};
    endfunction

    function automatic itype_e f_itype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return T_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return T_RI;
            OP_LW:                                         return T_LOAD;
            OP_SW:                                         return T_STORE;
            OP_BNEQZ, OP_BEQZ:                             return T_BRANCH;
            OP_HLT:                                        return T_HALT;
            default:                                       return T_NOP;
        endcase
    endfunction

    function automatic logic [2:0] f_alu_op(input logic [5:0] op);
        case (op)
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_AND:          return ALU_AND;
            OP_OR:           return ALU_OR;
            OP_SLT, OP_SLTI: return ALU_SLT;
            OP_MUL:          return ALU_MUL;
            default:         return ALU_ADD;
        endcase
    endfunction

    typedef struct packed {
        logic [XLEN_W-1:0] ir;
        logic [XLEN_W-1:0] npc;
    } if_id_t;

    typedef struct packed {
        logic [5:0]        op;
        logic [XLEN_W-1:0] npc;
        logic [XLEN_W-1:0] a;
        logic [XLEN_W-1:0] b;
        logic [XLEN_W-1:0] imm;
        itype_e            itype;
        logic [2:0]        alu_op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic              wen;
    } id_ex_t;

    typedef struct packed {
        itype_e            itype;
        logic [XLEN_W-1:0] alu_out;
        logic [XLEN_W-1:0] b;
        logic [4:0]        dest;
        logic              wen;
    } ex_mem_t;

    typedef struct packed {
        itype_e            itype;
        logic [XLEN_W-1:0] alu_out;
        logic [XLEN_W-1:0] lmd;
        logic [4:0]        dest;
        logic              wen;
    } mem_wb_t;

    localparam if_id_t IF_ID_NOP = '{ir: NOP_INSTR, npc: '0};
    localparam id_ex_t ID_EX_NOP = '{op: OP_OR, npc: '0, a: '0, b: '0, imm: '0, itype: T_RR,
                                     alu_op: ALU_OR, rs: '0, rt: '0, dest: '0, wen: 1'b0};
    localparam ex_mem_t EX_MEM_NOP = '{itype: T_RR, alu_out: '0, b: '0, dest: '0, wen: 1'b0};
    localparam mem_wb_t MEM_WB_NOP = '{itype: T_RR, alu_out: '0, lmd: '0, dest: '0, wen: 1'b0};

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the EX stage; all arithmetic wraps modulo 2^XLEN.
module mips32_alu
    import mips32_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = a_i + b_i;
        case (op_i)
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_MUL: result_o = a_i * b_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips32_pipe.sv
// Five-stage MIPS-32 subset core: unified memory, 32-entry register file, full forwarding,
// one-cycle load-use stall and branches resolved in EX with a two-slot squash.
module mips32_pipe
    import mips32_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int XLEN      = XLEN_W
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;
    logic [XLEN-1:0] Memory   [0:MEM_DEPTH-1];
    logic [XLEN-1:0] Register [0:31];

    if_id_t  if_id_q;
    id_ex_t  id_ex_q, id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q;

    assign halted = HALTED;

    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            mem_we;

    assign wb_data = (mem_wb_q.itype == T_LOAD) ? mem_wb_q.lmd : mem_wb_q.alu_out;
    assign wb_we   = mem_wb_q.wen && !HALTED;
    assign mem_we  = (ex_mem_q.itype == T_STORE) && !HALTED;

    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt, id_dest;
    itype_e          id_type;
    logic [XLEN-1:0] rs_val, rt_val;
    logic            uses_rt;
    logic            stall;

    // Register reads bypass a same-cycle WB write; R0 is hardwired to zero.
    always_comb begin
        id_op   = f_op(if_id_q.ir);
        id_rs   = f_rs(if_id_q.ir);
        id_rt   = f_rt(if_id_q.ir);
        id_type = f_itype(id_op);
        id_dest = (id_type == T_RR) ? f_rd(if_id_q.ir) : id_rt;
        rs_val  = (id_rs == 5'd0) ? '0 :
                  (wb_we && mem_wb_q.dest == id_rs) ? wb_data : Register[id_rs];
        rt_val  = (id_rt == 5'd0) ? '0 :
                  (wb_we && mem_wb_q.dest == id_rt) ? wb_data : Register[id_rt];
        uses_rt = (id_type == T_RR) || (id_type == T_STORE);
        stall   = (id_ex_q.itype == T_LOAD) && id_ex_q.wen &&
                  ((id_ex_q.dest == id_rs) || (uses_rt && id_ex_q.dest == id_rt));
        id_ex_d = '{op: id_op, npc: if_id_q.npc, a: rs_val, b: rt_val, imm: f_imm(if_id_q.ir),
                    itype: id_type, alu_op: f_alu_op(id_op), rs: id_rs, rt: id_rt, dest: id_dest,
                    wen: ((id_type == T_RR) || (id_type == T_RI) || (id_type == T_LOAD)) &&
                         (id_dest != 5'd0)};
    end

    logic [XLEN-1:0] a_fwd, b_fwd, alu_b, alu_out, br_target;
    logic            br_taken;

    // EX/MEM is newer than MEM/WB, so it is checked first; a load in EX/MEM has no data yet.
    always_comb begin
        if (ex_mem_q.wen && ex_mem_q.itype != T_LOAD && ex_mem_q.dest == id_ex_q.rs)
            a_fwd = ex_mem_q.alu_out;
        else if (mem_wb_q.wen && mem_wb_q.dest == id_ex_q.rs)
            a_fwd = wb_data;
        else
            a_fwd = id_ex_q.a;

        if (ex_mem_q.wen && ex_mem_q.itype != T_LOAD && ex_mem_q.dest == id_ex_q.rt)
            b_fwd = ex_mem_q.alu_out;
        else if (mem_wb_q.wen && mem_wb_q.dest == id_ex_q.rt)
            b_fwd = wb_data;
        else
            b_fwd = id_ex_q.b;

        alu_b     = (id_ex_q.itype == T_RR) ? b_fwd : id_ex_q.imm;
        br_target = id_ex_q.npc + id_ex_q.imm;
        // A branch younger than a HLT already in MEM must not redirect the frozen PC.
        br_taken  = (id_ex_q.itype == T_BRANCH) && (ex_mem_q.itype != T_HALT) &&
                    ((id_ex_q.op == OP_BNEQZ) ? (a_fwd != '0) : (a_fwd == '0));
        ex_mem_d  = '{itype: id_ex_q.itype, alu_out: alu_out, b: b_fwd,
                      dest: id_ex_q.dest, wen: id_ex_q.wen};
    end

    mips32_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (id_ex_q.alu_op),
        .a_i      (a_fwd),
        .b_i      (alu_b),
        .result_o (alu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id_q      <= IF_ID_NOP;
            id_ex_q      <= ID_EX_NOP;
            ex_mem_q     <= EX_MEM_NOP;
            mem_wb_q     <= MEM_WB_NOP;
        end else if (!HALTED) begin
            HALTED       <= (ex_mem_q.itype == T_HALT);
            TAKEN_BRANCH <= br_taken;
            if (br_taken) begin
                PC      <= br_target;
                if_id_q <= IF_ID_NOP;
            end else if (!stall) begin
                PC          <= PC + XLEN'(1);
                if_id_q.ir  <= Memory[PC[AW-1:0]];
                if_id_q.npc <= PC + XLEN'(1);
            end
            id_ex_q           <= (br_taken || stall) ? ID_EX_NOP : id_ex_d;
            ex_mem_q          <= ex_mem_d;
            mem_wb_q.itype    <= ex_mem_q.itype;
            mem_wb_q.alu_out  <= ex_mem_q.alu_out;
            mem_wb_q.lmd      <= Memory[ex_mem_q.alu_out[AW-1:0]];
            mem_wb_q.dest     <= ex_mem_q.dest;
            mem_wb_q.wen      <= ex_mem_q.wen;
        end
    end

    // Storage is never cleared; a write landing on a reset edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            if (mem_we)
                Memory[ex_mem_q.alu_out[AW-1:0]] <= ex_mem_q.b;
            if (wb_we)
                Register[mem_wb_q.dest] <= wb_data;
        end
    end

endmodule

// File: tb/tb_mips32_pipe.sv
// Directed bench for mips32_pipe: small preloaded programs run to HLT, results checked by hand values.
module tb_mips32_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    int errors = 0;
    int checks = 0;
    int taken_cnt = 0;
    logic [31:0] prog_q [$];

    localparam logic [31:0] HLT_I = 32'hfc000000;

    mips32_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst)
            taken_cnt = 0;
        else if (!halted && dut.TAKEN_BRANCH)
            taken_cnt = taken_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_ins(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0];
        t = rt[4:0];
        d = rd[4:0];
        return {op, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [4:0]  s, t;
        logic [15:0] k;
        s = rs[4:0];
        t = rt[4:0];
        k = imm[15:0];
        return {op, s, t, k};
    endfunction

    task automatic setup();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Memory[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.Register[i] = 32'd0;
        for (int i = 0; i < prog_q.size(); i++) dut.Memory[i] = prog_q[i];
    endtask

    task automatic run(input string name, output int cycles);
        cycles = 0;
        @(negedge clk);
        rst = 1'b0;
        while (halted !== 1'b1 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt: halted=%b required 1 within 1000 cycles", name, halted);
        end
        $display("run %s: halted after %0d cycles", name, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.PC !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h required 0", dut.PC); end
        checks++;
        if (dut.HALTED !== 1'b0) begin errors++; $display("FAIL reset_HALTED: got %b required 0", dut.HALTED); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++;
        if (dut.TAKEN_BRANCH !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b required 0", dut.TAKEN_BRANCH); end
    endtask

    task automatic test_straight_alu();
        int cyc;
        prog_q = '{i_ins(6'b001010, 0, 1, 5), i_ins(6'b001010, 0, 2, 7), r_ins(6'b000000, 1, 2, 3),
                   r_ins(6'b000001, 2, 1, 4), i_ins(6'b001100, 1, 5, 6), HLT_I};
        setup();
        run("straight", cyc);
        checks++;
        if (dut.Register[3] !== 32'd12) begin errors++; $display("FAIL straight_r3: got %h required 0000000c", dut.Register[3]); end
        checks++;
        if (dut.Register[4] !== 32'd2) begin errors++; $display("FAIL straight_r4: got %h required 00000002", dut.Register[4]); end
        checks++;
        if (dut.Register[5] !== 32'd1) begin errors++; $display("FAIL straight_r5: got %h required 00000001", dut.Register[5]); end
    endtask

    task automatic test_alu_ops();
        int cyc;
        prog_q = '{i_ins(6'b001010, 0, 1, -3), i_ins(6'b001010, 0, 2, 6), r_ins(6'b000010, 1, 2, 3),
                   r_ins(6'b000011, 1, 2, 4), r_ins(6'b000100, 1, 2, 5), r_ins(6'b000100, 2, 1, 9),
                   r_ins(6'b000101, 1, 2, 11), r_ins(6'b000000, 1, 2, 0), r_ins(6'b000000, 0, 2, 12),
                   i_ins(6'b001100, 1, 13, -2), i_ins(6'b001011, 0, 14, 1), HLT_I};
        setup();
        dut.Register[0] = 32'h00000055;
        dut.Register[9] = 32'h00000077;
        run("aluops", cyc);
        checks++;
        if (dut.Register[3] !== 32'h00000004) begin errors++; $display("FAIL and_neg: got %h required 00000004", dut.Register[3]); end
        checks++;
        if (dut.Register[4] !== 32'hffffffff) begin errors++; $display("FAIL or_neg: got %h required ffffffff", dut.Register[4]); end
        checks++;
        if (dut.Register[5] !== 32'd1) begin errors++; $display("FAIL slt_true: got %h required 00000001", dut.Register[5]); end
        checks++;
        if (dut.Register[9] !== 32'd0) begin errors++; $display("FAIL slt_false: got %h required 00000000", dut.Register[9]); end
        checks++;
        if (dut.Register[11] !== 32'hffffffee) begin errors++; $display("FAIL mul_neg: got %h required ffffffee", dut.Register[11]); end
        checks++;
        if (dut.Register[12] !== 32'd6) begin errors++; $display("FAIL r0_reads_zero: got %h required 00000006", dut.Register[12]); end
        checks++;
        if (dut.Register[0] !== 32'h00000055) begin errors++; $display("FAIL r0_write_ignored: got %h required 00000055", dut.Register[0]); end
        checks++;
        if (dut.Register[13] !== 32'd1) begin errors++; $display("FAIL slti_neg: got %h required 00000001", dut.Register[13]); end
        checks++;
        if (dut.Register[14] !== 32'hffffffff) begin errors++; $display("FAIL subi_wrap: got %h required ffffffff", dut.Register[14]); end
    endtask

    task automatic test_load_use();
        int c_ref, c_dep;
        prog_q = '{32'h280a00c8, 32'h21430000, i_ins(6'b001011, 9, 4, 1), HLT_I};
        setup();
        dut.Memory[200] = 32'd3;
        run("load_nodep", c_ref);
        checks++;
        if (dut.Register[3] !== 32'd3) begin errors++; $display("FAIL lw_value: got %h required 00000003", dut.Register[3]); end
        checks++;
        if (dut.Register[4] !== 32'hffffffff) begin errors++; $display("FAIL lw_nodep_r4: got %h required ffffffff", dut.Register[4]); end

        prog_q = '{32'h280a00c8, 32'h21430000, 32'h2c630001, HLT_I};
        setup();
        dut.Memory[200] = 32'd3;
        run("load_use", c_dep);
        checks++;
        if (dut.Register[3] !== 32'd2) begin errors++; $display("FAIL load_use_r3: got %h required 00000002", dut.Register[3]); end
        checks++;
        if (c_dep !== c_ref + 1) begin errors++; $display("FAIL load_use_stall: got %0d cycles required %0d", c_dep, c_ref + 1); end
    endtask

    task automatic load_factorial(input logic [31:0] at5);
        prog_q = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                   at5, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe, HLT_I};
        setup();
        dut.Memory[200] = 32'd3;
    endtask

    task automatic test_factorial_nomul();
        int cyc;
        load_factorial(32'h0e94a000);
        run("fact_nomul", cyc);
        checks++;
        if (dut.Memory[198] !== 32'd1) begin errors++; $display("FAIL fact_nomul_mem: got %h required 00000001", dut.Memory[198]); end
    endtask

    task automatic test_branch_squash();
        int cyc;
        prog_q = '{i_ins(6'b001110, 0, 0, 2), i_ins(6'b001010, 0, 6, 9), i_ins(6'b001010, 0, 7, 9),
                   i_ins(6'b001010, 0, 8, 1), HLT_I};
        setup();
        run("branch", cyc);
        checks++;
        if (dut.Register[6] !== 32'd0) begin errors++; $display("FAIL squash_r6: got %h required 00000000", dut.Register[6]); end
        checks++;
        if (dut.Register[7] !== 32'd0) begin errors++; $display("FAIL squash_r7: got %h required 00000000", dut.Register[7]); end
        checks++;
        if (dut.Register[8] !== 32'd1) begin errors++; $display("FAIL target_r8: got %h required 00000001", dut.Register[8]); end
        checks++;
        if (taken_cnt !== 1) begin errors++; $display("FAIL taken_pulse: got %0d cycles required 1", taken_cnt); end
    endtask

    task automatic test_factorial_and_halt();
        int cyc;
        logic [31:0] pc0, m198, m0;
        logic [31:0] regs [0:31];
        logic diff;
        load_factorial(32'h14431000);
        run("factorial", cyc);
        checks++;
        if (dut.Memory[198] !== 32'd6) begin errors++; $display("FAIL fact_mem198: got %h required 00000006", dut.Memory[198]); end
        checks++;
        if (dut.Register[2] !== 32'd6) begin errors++; $display("FAIL fact_r2: got %h required 00000006", dut.Register[2]); end
        checks++;
        if (dut.Register[3] !== 32'd0) begin errors++; $display("FAIL fact_r3: got %h required 00000000", dut.Register[3]); end
        checks++;
        if (taken_cnt !== 2) begin errors++; $display("FAIL fact_taken: got %0d required 2", taken_cnt); end

        pc0  = dut.PC;
        m198 = dut.Memory[198];
        m0   = dut.Memory[0];
        for (int i = 0; i < 32; i++) regs[i] = dut.Register[i];
        repeat (20) @(negedge clk);
        checks++;
        if (dut.PC !== pc0) begin errors++; $display("FAIL frozen_pc: got %h required %h", dut.PC, pc0); end
        diff = 1'b0;
        for (int i = 0; i < 32; i++) if (dut.Register[i] !== regs[i]) diff = 1'b1;
        checks++;
        if (diff !== 1'b0) begin errors++; $display("FAIL frozen_regs: got changed=%b required 0", diff); end
        checks++;
        if (dut.Memory[198] !== m198) begin errors++; $display("FAIL frozen_mem: got %h required %h", dut.Memory[198], m198); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL frozen_halted: got %b required 1", halted); end

        rst = 1'b1;
        #1;
        checks++;
        if (dut.PC !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h required 00000000", dut.PC); end
        checks++;
        if (dut.HALTED !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got HALTED=%b halted=%b required 0/0", dut.HALTED, halted); end
        checks++;
        if (dut.Memory[198] !== 32'd6 || dut.Memory[0] !== m0) begin
            errors++;
            $display("FAIL rst_mem_kept: got m198=%h m0=%h required 00000006/%h", dut.Memory[198], dut.Memory[0], m0);
        end
        checks++;
        if (dut.Register[2] !== 32'd6) begin errors++; $display("FAIL rst_reg_kept: got %h required 00000006", dut.Register[2]); end
    endtask

    initial begin
        test_reset();
        test_straight_alu();
        test_alu_ops();
        test_load_use();
        test_factorial_nomul();
        test_branch_squash();
        test_factorial_and_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
